pr_scoreboard_ckpt: RTL and testbench

Second-generation physical-register scoreboard for the rename/dispatch path. It tracks free and valid state for every physical register (PR) and presents up to PR_ALLOC_PRTS allocatable PRs per cycle, each with an explicit valid handshake. It snoops the PRF write ports to mark PRs valid, and frees PRs on commit. New in this generation: branch checkpoints of the free vector, so a misprediction restores allocation state in one cycle. The ISA register count is also parametrised.

---
 rtl/pr_scoreboard_ckpt_if.sv | 58 +++++
 rtl/pr_scoreboard_ckpt.sv | 149 ++++++++++++++
 tb/tb_pr_scoreboard_ckpt.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pr_scoreboard_ckpt_if.sv
// Rename-side bus of the physical-register scoreboard.
// Groups the allocation handshake, commit free mask, PRF write snoop and the
// branch-checkpoint controls. The scoreboard connects through the slave
// modport; the rename/dispatch logic (or a bench) uses the master modport.
//   i_alloc_pr      take the PR presented on each allocation port
//   o_alloc_vld     allocation port presents a real free PR
//   o_allocd_reg    PR presented on each allocation port
//   o_alloc_av      number of free PRs (PRW+1 bits, can reach NUM_PHYSICAL_REGS)
//   i_free_pr       commit-side free mask
//   o_pr_valid      PR holds written data
//   i_prf_we        PRF write enables (snooped)
//   i_prf_wr_trgt   PRF write targets (snooped)
//   i_ckpt_save     snapshot the free vector into slot i_ckpt_id
//   i_ckpt_restore  roll back to slot i_ckpt_id
//   i_ckpt_id       slot used by save or restore
//   i_ckpt_release  slots discarded after correct branch resolution
//   i_ckpt_kill     extra slots invalidated together with a restore
//   o_ckpt_busy     slot holds a live snapshot
//   o_ckpt_err      one-cycle pulse on save to a busy slot / restore of an idle slot
interface pr_scoreboard_ckpt_if #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int PR_ALLOC_PRTS     = 2,
  parameter int NUM_PRF_WR_PRTS   = 4,
  parameter int NUM_CKPTS         = 4
);
  localparam int PRW = $clog2(NUM_PHYSICAL_REGS);
  localparam int CKW = $clog2(NUM_CKPTS);

  logic [PR_ALLOC_PRTS-1:0]            i_alloc_pr;
  logic [PR_ALLOC_PRTS-1:0]            o_alloc_vld;
  logic [PR_ALLOC_PRTS-1:0][PRW-1:0]   o_allocd_reg;
  logic [PRW:0]                        o_alloc_av;
  logic [NUM_PHYSICAL_REGS-1:0]        i_free_pr;
  logic [NUM_PHYSICAL_REGS-1:0]        o_pr_valid;
  logic [NUM_PRF_WR_PRTS-1:0]          i_prf_we;
  logic [NUM_PRF_WR_PRTS-1:0][PRW-1:0] i_prf_wr_trgt;
  logic                                i_ckpt_save;
  logic                                i_ckpt_restore;
  logic [CKW-1:0]                      i_ckpt_id;
  logic [NUM_CKPTS-1:0]                i_ckpt_release;
  logic [NUM_CKPTS-1:0]                i_ckpt_kill;
  logic [NUM_CKPTS-1:0]                o_ckpt_busy;
  logic                                o_ckpt_err;

  modport slave (
    input  i_alloc_pr, i_free_pr, i_prf_we, i_prf_wr_trgt,
           i_ckpt_save, i_ckpt_restore, i_ckpt_id, i_ckpt_release, i_ckpt_kill,
    output o_alloc_vld, o_allocd_reg, o_alloc_av, o_pr_valid,
           o_ckpt_busy, o_ckpt_err
  );

  modport master (
    output i_alloc_pr, i_free_pr, i_prf_we, i_prf_wr_trgt,
           i_ckpt_save, i_ckpt_restore, i_ckpt_id, i_ckpt_release, i_ckpt_kill,
    input  o_alloc_vld, o_allocd_reg, o_alloc_av, o_pr_valid,
           o_ckpt_busy, o_ckpt_err
  );
endinterface

// File: rtl/pr_scoreboard_ckpt.sv
// Physical-register scoreboard with branch checkpoints.
// Tracks free/valid state of every PR, presents the lowest-indexed free PRs on
// the allocation ports, marks PRs valid on snooped PRF writes, frees PRs on
// commit, and snapshots/restores the free vector for branch recovery.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      pr_scoreboard_ckpt_if.slave (allocation, free, PRF snoop, checkpoints)
// All outputs are decoded from registered state only.
module pr_scoreboard_ckpt #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int NUM_ISA_REGS      = 19,
  parameter int PR_ALLOC_PRTS     = 2,
  parameter int NUM_PRF_WR_PRTS   = 4,
  parameter int NUM_CKPTS         = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pr_scoreboard_ckpt_if.slave    bus
);
  localparam int N   = NUM_PHYSICAL_REGS;
  localparam int PRW = $clog2(NUM_PHYSICAL_REGS);

  function automatic logic [N-1:0] isa_mask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ISA_REGS; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [PRW:0] pop_count(input logic [N-1:0] v);
    logic [PRW:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {{PRW{1'b0}}, v[i]};
    return c;
  endfunction

  logic [N-1:0]                    free_q, free_n;
  logic [N-1:0]                    valid_q, valid_n;
  logic [NUM_CKPTS-1:0][N-1:0]     ckpt_free_q, ckpt_free_n;
  logic [NUM_CKPTS-1:0]            ckpt_vld_q, ckpt_vld_n;
  logic                            err_q, err_n;

  logic [PR_ALLOC_PRTS-1:0][PRW-1:0] sel;
  logic [PR_ALLOC_PRTS-1:0]          avld;
  logic [PRW:0]                      av;
  logic [N-1:0]                      restored;
  logic                              restore_ok;
  int                                seen;

  // Presentation: port p gets the p-th lowest free PR of the registered vector
  always_comb begin
    sel  = '0;
    seen = 0;
    for (int i = 0; i < N; i++) begin
      if (free_q[i]) begin
        for (int p = 0; p < PR_ALLOC_PRTS; p++)
          if (seen == p) sel[p] = PRW'(i);
        seen = seen + 1;
      end
    end
  end

  always_comb begin
    av = pop_count(free_q);
    for (int p = 0; p < PR_ALLOC_PRTS; p++)
      avld[p] = (av > (PRW+1)'(p));
  end

  // Next state: frees, allocs, checkpoint ops, then PRF-write snoop
  always_comb begin
    free_n      = free_q;
    valid_n     = valid_q;
    ckpt_free_n = ckpt_free_q;
    ckpt_vld_n  = ckpt_vld_q;
    err_n       = 1'b0;
    restored    = '0;
    restore_ok  = bus.i_ckpt_restore && ckpt_vld_q[bus.i_ckpt_id];

    // Committed frees also land in every live snapshot so a rollback keeps them
    free_n  = free_n | bus.i_free_pr;
    valid_n = valid_n & ~bus.i_free_pr;
    for (int k = 0; k < NUM_CKPTS; k++)
      if (ckpt_vld_q[k]) ckpt_free_n[k] = ckpt_free_q[k] | bus.i_free_pr;

    if (!restore_ok) begin
      for (int p = 0; p < PR_ALLOC_PRTS; p++) begin
        if (bus.i_alloc_pr[p] && avld[p]) begin
          free_n[sel[p]]  = 1'b0;
          valid_n[sel[p]] = 1'b0;
        end
      end
    end

    ckpt_vld_n = ckpt_vld_n & ~bus.i_ckpt_release;

    if (restore_ok) begin
      restored = ckpt_free_q[bus.i_ckpt_id] | bus.i_free_pr;
      // PRs handed back by the rollback lose any data they were given
      valid_n  = valid_n & ~(restored & ~free_n);
      free_n   = restored;
      ckpt_vld_n[bus.i_ckpt_id] = 1'b0;
      ckpt_vld_n = ckpt_vld_n & ~bus.i_ckpt_kill;
    end else begin
      if (bus.i_ckpt_restore) err_n = 1'b1;
      if (bus.i_ckpt_save) begin
        // A release of the same slot this cycle makes room for the new snapshot
        if (ckpt_vld_q[bus.i_ckpt_id] && !bus.i_ckpt_release[bus.i_ckpt_id]) begin
          err_n = 1'b1;
        end else begin
          ckpt_free_n[bus.i_ckpt_id] = free_n;
          ckpt_vld_n[bus.i_ckpt_id]  = 1'b1;
        end
      end
    end

    // Writes to PRs that are free after frees/rollback are stale and dropped
    for (int w = 0; w < NUM_PRF_WR_PRTS; w++)
      if (bus.i_prf_we[w] && !free_n[bus.i_prf_wr_trgt[w]])
        valid_n[bus.i_prf_wr_trgt[w]] = 1'b1;
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      free_q     <= ~isa_mask();
      valid_q    <= isa_mask();
      ckpt_vld_q <= '0;
      err_q      <= 1'b0;
    end else begin
      free_q     <= free_n;
      valid_q    <= valid_n;
      ckpt_vld_q <= ckpt_vld_n;
      err_q      <= err_n;
    end
  end

  // Snapshot storage is qualified by ckpt_vld_q and needs no reset
  always_ff @(posedge i_clk) begin
    ckpt_free_q <= ckpt_free_n;
  end

  assign bus.o_alloc_vld  = avld;
  assign bus.o_allocd_reg = sel;
  assign bus.o_alloc_av   = av;
  assign bus.o_pr_valid   = valid_q;
  assign bus.o_ckpt_busy  = ckpt_vld_q;
  assign bus.o_ckpt_err   = err_q;
endmodule

// File: tb/tb_pr_scoreboard_ckpt.sv
module tb_pr_scoreboard_ckpt;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  pr_scoreboard_ckpt_if #(.NUM_PHYSICAL_REGS(64), .PR_ALLOC_PRTS(2),
                          .NUM_PRF_WR_PRTS(4), .NUM_CKPTS(4)) bus ();

  pr_scoreboard_ckpt #(.NUM_PHYSICAL_REGS(64), .NUM_ISA_REGS(19), .PR_ALLOC_PRTS(2),
                       .NUM_PRF_WR_PRTS(4), .NUM_CKPTS(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_alloc_pr     = '0;
    bus.i_free_pr      = '0;
    bus.i_prf_we       = '0;
    bus.i_prf_wr_trgt  = '0;
    bus.i_ckpt_save    = 1'b0;
    bus.i_ckpt_restore = 1'b0;
    bus.i_ckpt_id      = '0;
    bus.i_ckpt_release = '0;
    bus.i_ckpt_kill    = '0;
  endtask

  // Apply the prepared inputs for one edge, then sample 1 ns after it
  task automatic tick();
    @(posedge i_clk);
    #1;
    clear_inputs();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_reg0"}, bus.o_allocd_reg[0], 19);
    chk({tag, "_reg1"}, bus.o_allocd_reg[1], 20);
    chk({tag, "_vld"},  bus.o_alloc_vld, 2'b11);
    chk({tag, "_av"},   bus.o_alloc_av, 45);
    chk({tag, "_prv"},  bus.o_pr_valid, 64'h7FFFF);
    chk({tag, "_busy"}, bus.o_ckpt_busy, 4'b0000);
    chk({tag, "_err"},  bus.o_ckpt_err, 1'b0);
  endtask

  initial begin
    clear_inputs();
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    #1 chk_reset_state("rst_async");
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Scenario 1: idle after reset
    tick();
    chk_reset_state("idle");

    // Scenario 2: allocate two, then write PR 19
    bus.i_alloc_pr = 2'b11;
    tick();
    chk("a2_reg0", bus.o_allocd_reg[0], 21);
    chk("a2_reg1", bus.o_allocd_reg[1], 22);
    chk("a2_av",   bus.o_alloc_av, 43);
    chk("a2_prv",  bus.o_pr_valid, 64'h7FFFF);
    bus.i_prf_we[0] = 1'b1; bus.i_prf_wr_trgt[0] = 6'd19;
    tick();
    chk("wr19_prv", bus.o_pr_valid, 64'hFFFFF);
    chk("wr19_av",  bus.o_alloc_av, 43);

    // Asynchronous reset away from a clock edge
    #2 i_rst_n = 1'b0;
    #1 chk_reset_state("rst_mid1");
    i_rst_n = 1'b1;

    // Scenario 4: save slot 2, allocate 4, free PR 5, restore
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd2;
    tick();
    chk("s4_busy", bus.o_ckpt_busy, 4'b0100);
    chk("s4_av0",  bus.o_alloc_av, 45);
    chk("s4_err0", bus.o_ckpt_err, 1'b0);
    bus.i_alloc_pr = 2'b11; tick();
    bus.i_alloc_pr = 2'b11; tick();
    chk("s4_av1",   bus.o_alloc_av, 41);
    chk("s4_reg0a", bus.o_allocd_reg[0], 23);
    chk("s4_reg1a", bus.o_allocd_reg[1], 24);
    bus.i_free_pr[5] = 1'b1;
    tick();
    chk("s4_av2",   bus.o_alloc_av, 42);
    chk("s4_reg0b", bus.o_allocd_reg[0], 5);
    chk("s4_prv",   bus.o_pr_valid, 64'h7FFDF);
    bus.i_ckpt_restore = 1'b1; bus.i_ckpt_id = 2'd2;
    tick();
    chk("s4_av3",   bus.o_alloc_av, 46);
    chk("s4_reg0c", bus.o_allocd_reg[0], 5);
    chk("s4_reg1c", bus.o_allocd_reg[1], 19);
    chk("s4_busy2", bus.o_ckpt_busy, 4'b0000);

    // Scenario 5: busy-slot save error, snapshot preserved, release+save
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd1;
    tick();
    chk("s5_busy", bus.o_ckpt_busy, 4'b0010);
    bus.i_alloc_pr = 2'b11;
    tick();
    chk("s5_av",   bus.o_alloc_av, 44);
    chk("s5_reg0", bus.o_allocd_reg[0], 20);
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd1;
    tick();
    chk("s5_err1",  bus.o_ckpt_err, 1'b1);
    chk("s5_busy1", bus.o_ckpt_busy, 4'b0010);
    tick();
    chk("s5_err0",  bus.o_ckpt_err, 1'b0);
    bus.i_ckpt_restore = 1'b1; bus.i_ckpt_id = 2'd1;
    tick();
    chk("s5_rst_av",   bus.o_alloc_av, 46);
    chk("s5_rst_reg0", bus.o_allocd_reg[0], 5);
    chk("s5_rst_reg1", bus.o_allocd_reg[1], 19);
    chk("s5_rst_busy", bus.o_ckpt_busy, 4'b0000);
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd1;
    tick();
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd1; bus.i_ckpt_release = 4'b0010;
    tick();
    chk("s5_rs_busy", bus.o_ckpt_busy, 4'b0010);
    chk("s5_rs_err",  bus.o_ckpt_err, 1'b0);
    bus.i_ckpt_release = 4'b0010;
    tick();
    chk("s5_rel_busy", bus.o_ckpt_busy, 4'b0000);

    // Restore with kill mask, then restore of an idle slot
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd0; tick();
    bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd3; tick();
    chk("kill_busy0", bus.o_ckpt_busy, 4'b1001);
    bus.i_ckpt_restore = 1'b1; bus.i_ckpt_id = 2'd0; bus.i_ckpt_kill = 4'b1000;
    tick();
    chk("kill_busy1", bus.o_ckpt_busy, 4'b0000);
    chk("kill_av",    bus.o_alloc_av, 46);
    bus.i_ckpt_restore = 1'b1; bus.i_ckpt_id = 2'd2;
    tick();
    chk("idle_rst_err", bus.o_ckpt_err, 1'b1);
    chk("idle_rst_av",  bus.o_alloc_av, 46);

    // Scenario 6: free and PRF write to the same PR in one cycle
    bus.i_free_pr[3]  = 1'b1; bus.i_free_pr[30] = 1'b1;
    bus.i_prf_we = 4'b0011;
    bus.i_prf_wr_trgt[0] = 6'd3; bus.i_prf_wr_trgt[1] = 6'd30;
    tick();
    chk("s6_prv",  bus.o_pr_valid, 64'h7FFD7);
    chk("s6_av",   bus.o_alloc_av, 47);
    chk("s6_reg0", bus.o_allocd_reg[0], 3);
    chk("s6_reg1", bus.o_allocd_reg[1], 5);
    bus.i_alloc_pr = 2'b11;
    tick();
    chk("s6_av2", bus.o_alloc_av, 45);
    bus.i_prf_we[3] = 1'b1; bus.i_prf_wr_trgt[3] = 6'd5;
    tick();
    chk("wr3_prv", bus.o_pr_valid, 64'h7FFF7);

    // Scenario 3: exhaust the free list
    for (int c = 0; c < 22; c++) begin
      bus.i_alloc_pr = 2'b11;
      tick();
    end
    chk("ex_vld",  bus.o_alloc_vld, 2'b01);
    chk("ex_av",   bus.o_alloc_av, 1);
    chk("ex_reg0", bus.o_allocd_reg[0], 63);
    bus.i_alloc_pr = 2'b11;
    tick();
    chk("ex0_av",  bus.o_alloc_av, 0);
    chk("ex0_vld", bus.o_alloc_vld, 2'b00);

    // Free everything: count must reach 64 without wrapping
    bus.i_free_pr = '1;
    tick();
    chk("all_av",   bus.o_alloc_av, 64);
    chk("all_prv",  bus.o_pr_valid, 64'h0);
    chk("all_reg0", bus.o_allocd_reg[0], 0);
    chk("all_reg1", bus.o_allocd_reg[1], 1);
    chk("all_vld",  bus.o_alloc_vld, 2'b11);

    // Reset in the middle of activity with a live checkpoint
    bus.i_alloc_pr = 2'b11; bus.i_ckpt_save = 1'b1; bus.i_ckpt_id = 2'd0;
    tick();
    chk("pre_rst_av",   bus.o_alloc_av, 62);
    chk("pre_rst_busy", bus.o_ckpt_busy, 4'b0001);
    #2 i_rst_n = 1'b0;
    #1 chk_reset_state("rst_mid2");
    i_rst_n = 1'b1;
    tick();
    chk_reset_state("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
